alu_issue_sched: RTL and testbench
==================================

// Module: alu_issue_sched
// PURPOSE
//  Shares the single backend ALU between NUM_REQ issue requesters (reservation-station ports).
//  Round-robin arbitration, operand steering into the combinational ALU, and MUL_I sequencing as a multicycle op.
//  Results are registered and held on a valid/ready writeback port until drained.
//  Sits between the RS issue ports and the CDB/writeback arbiter.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  TAG_W    6  destination tag width (ROB/phys-reg tag)
//  MUL_LAT  3  cycles MUL_I operands are held on the ALU before capture (>=2)
// PORTS
//  clk          in   1                    clock, rising edge
//  rst_n        in   1                    reset, asynchronous, active-low
//  flush        in   1                    sync pipeline flush (mispredict/exception)
//  req_valid    in   NUM_REQ              requester i has an op
//  req_ready    out  NUM_REQ              one-hot grant; handshake = valid&ready
//  req_opcode   in   NUM_REQ x instr_opcode  per-requester opcode
//  req_val1     in   NUM_REQ x 32         operand 1
//  req_val2     in   NUM_REQ x 32         operand 2 (already imm-selected)
//  req_tag      in   NUM_REQ x TAG_W      destination tag
//  alu_en       out  1                    ALU enable
//  alu_opcode   out  instr_opcode         ALU opcode
//  alu_val1     out  32                   ALU operand 1
//  alu_val2     out  32                   ALU operand 2
//  alu_result   in   32                   ALU aluout
//  alu_result_valid in 1                  ALU aluout_valid
//  alu_br_cond  in   1                    ALU br_cond
//  wb_valid     out  1                    result register valid
//  wb_ready     in   1                    consumer accepts
//  wb_tag       out  TAG_W                result tag
//  wb_data      out  32                   result data
//  wb_br_cond   out  1                    branch condition
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, wb_valid=0, wb_tag/wb_data/wb_br_cond=0, mul_cnt=0, alu_en=0, req_ready=0.
//  States: IDLE, MUL, HOLD.
//  can_issue = (state==IDLE) & (!wb_valid | wb_ready) & !flush.
//  IDLE: if can_issue & |req_valid, grant first valid index at/after rr_ptr (wrap mod NUM_REQ).
//    req_ready[g]=1, the ALU is driven combinationally from requester g, and alu_en=1.
//    Non-MUL op: capture alu_result/alu_br_cond/tag at the edge; wb_valid=1 next cycle (latency 1).
//    MUL_I: latch op, operands and tag; go to MUL with mul_cnt=MUL_LAT-1.
//    On every handshake, rr_ptr <= g+1 (wraps).
//  MUL: ALU is driven from the latched op with alu_en=1 and req_ready=0. mul_cnt decrements.
//    At mul_cnt==1: if !wb_valid | wb_ready, capture at this edge (total latency MUL_LAT) and return to IDLE; else go to HOLD.
//  HOLD: the ALU is held driven. Capture on the first cycle with !wb_valid | wb_ready, then go to IDLE.
//  wb_*: stable while wb_valid & !wb_ready. Clear on wb_valid & wb_ready unless a new capture occurs the same edge (back-to-back throughput 1/cycle).
//  Capture writes alu_result exactly; alu_result_valid=0 at a capture edge is a protocol error (assertion).
//  flush: wb_valid<=0, any MUL/HOLD op is dropped, state<=IDLE, rr_ptr unchanged, req_ready=0 that cycle.
//  Reset mid-MUL: immediate return to reset values; nothing is emitted.
//  No req_valid: alu_en=0, alu_* operands driven 0.
// CONFIGURATION
//  ALU_ISSUE_SCHED_PERF_EN defined: adds outputs perf_issue_cnt[31:0] (+1 per handshake) and perf_stall_cnt[31:0] (+1 per cycle with |req_valid & !can_issue).
//    Both saturate at 2^32-1 and reset to 0 on rst_n only, not on flush.
//  Undefined: those ports and counters do not exist.
// STRUCTURE
//  instr_opcode enum stays in the shared backend package.
//  Add to that package: typedef alu_issue_t {instr_opcode op; logic [31:0] v1,v2; logic [TAG_W-1:0] tag;} and localparam state enum sched_state_t.
//  Sub-module rr_arbiter #(NUM_REQ): inputs req, ptr; output one-hot gnt (combinational), reused by other backend arbiters.
// TESTING
//  1) Reset with all req_valid=1 -> req_ready=0, wb_valid=0. After release, grants go 0,1,2,3,0 on consecutive cycles with wb_ready=1.
//  2) Requester 2 ADD_I 5,7, tag 9 -> next cycle wb_valid=1, wb_data=12, wb_tag=9. No other requester is granted while wb_ready=0.
//  3) MUL_I 0xFFFFFFFE x 3 (MUL_LAT=3) -> wb_data=0xFFFFFFFA exactly 3 cycles after handshake; req_ready=0 throughout.
//  4) BLT_I val1=-1, val2=1 -> wb_br_cond=1. BLTU_I with the same operands -> wb_br_cond=0.
//  5) flush in the 2nd MUL cycle -> no wb_valid, IDLE next cycle, next grant follows the rr_ptr held from before.
//  6) With ALU_ISSUE_SCHED_PERF_EN: 4 issues and 3 wb_ready=0 stall cycles -> perf_issue_cnt=4, perf_stall_cnt=3.

Source files
------------

// File: rtl/alu_issue_sched_pkg.sv
// rtl/alu_issue_sched_pkg.sv - shared backend opcode, issue payload and scheduler state encodings
package alu_issue_sched_pkg;

  // Backend ALU opcode set shared by every reservation station and the ALU
  typedef enum logic [3:0] {
    ADD_I  = 4'd0,
    SUB_I  = 4'd1,
    AND_I  = 4'd2,
    OR_I   = 4'd3,
    XOR_I  = 4'd4,
    SLL_I  = 4'd5,
    SRL_I  = 4'd6,
    SLT_I  = 4'd7,
    SLTU_I = 4'd8,
    MUL_I  = 4'd9,
    BEQ_I  = 4'd10,
    BNE_I  = 4'd11,
    BLT_I  = 4'd12,
    BGE_I  = 4'd13,
    BLTU_I = 4'd14,
    BGEU_I = 4'd15
  } instr_opcode;

  // Destination tag width carried in the latched issue payload
  localparam int ISSUE_TAG_W = 6;

  // One issued operation as steered into the ALU
  typedef struct packed {
    instr_opcode             op;
    logic [31:0]             v1;
    logic [31:0]             v2;
    logic [ISSUE_TAG_W-1:0]  tag;
  } alu_issue_t;

  // Scheduler states
  typedef logic [1:0] sched_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot grant starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Walk from the farthest candidate back to ptr so the nearest valid requester wins
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[PTR_W'(idx)]) begin
        gnt = '0;
        gnt[PTR_W'(idx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - round-robin ALU issue scheduler with MUL sequencing; ALU_ISSUE_SCHED_PERF_EN adds perf counters
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = ISSUE_TAG_W,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  instr_opcode        req_opcode [NUM_REQ],
  input  logic [31:0]        req_val1   [NUM_REQ],
  input  logic [31:0]        req_val2   [NUM_REQ],
  input  logic [TAG_W-1:0]   req_tag    [NUM_REQ],
  output logic               alu_en,
  output instr_opcode        alu_opcode,
  output logic [31:0]        alu_val1,
  output logic [31:0]        alu_val2,
  input  logic [31:0]        alu_result,
  input  logic               alu_result_valid,
  input  logic               alu_br_cond,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [TAG_W-1:0]   wb_tag,
  output logic [31:0]        wb_data,
  output logic               wb_br_cond
`ifdef ALU_ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_issue_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_START = CNT_W'(MUL_LAT - 1);

  sched_state_t       state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   ptr_next;
  logic [CNT_W-1:0]   mul_cnt;
  logic [NUM_REQ-1:0] gnt;
  alu_issue_t         lat;
  alu_issue_t         cur;
  logic               wb_free;
  logic               can_issue;
  logic               issue;
  logic               capture;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Issue qualification, grant index and the granted requester's payload
  always_comb begin
    wb_free   = !wb_valid || wb_ready;
    can_issue = rst_n && (state == ST_IDLE) && wb_free && !flush;
    issue     = can_issue && (|req_valid);
    req_ready = can_issue ? gnt : '0;
    gidx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gidx = PTR_W'(i);
    end
    ptr_next  = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    cur.op    = req_opcode[gidx];
    cur.v1    = req_val1[gidx];
    cur.v2    = req_val2[gidx];
    cur.tag   = ISSUE_TAG_W'(req_tag[gidx]);
  end

  // Result capture: single-cycle ops at issue, MUL on its last cycle or once writeback frees up
  always_comb begin
    capture = 1'b0;
    if (issue) begin
      capture = (cur.op != MUL_I);
    end else if (!flush) begin
      if (state == ST_MUL)       capture = (mul_cnt == CNT_W'(1)) && wb_free;
      else if (state == ST_HOLD) capture = wb_free;
    end
  end

  // ALU steering: live requester on issue, latched op while a MUL is in flight
  always_comb begin
    alu_en     = 1'b0;
    alu_opcode = ADD_I;
    alu_val1   = '0;
    alu_val2   = '0;
    if (issue) begin
      alu_en     = 1'b1;
      alu_opcode = cur.op;
      alu_val1   = cur.v1;
      alu_val2   = cur.v2;
    end else if (state != ST_IDLE) begin
      alu_en     = 1'b1;
      alu_opcode = lat.op;
      alu_val1   = lat.v1;
      alu_val2   = lat.v2;
    end
  end

  // Scheduler FSM, round-robin pointer and MUL countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      mul_cnt <= '0;
      lat     <= '0;
    end else if (flush) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            rr_ptr <= ptr_next;
            if (cur.op == MUL_I) begin
              state   <= ST_MUL;
              mul_cnt <= MUL_START;
              lat     <= cur;
            end
          end
        end
        ST_MUL: begin
          mul_cnt <= mul_cnt - 1'b1;
          if (mul_cnt == CNT_W'(1)) state <= capture ? ST_IDLE : ST_HOLD;
        end
        ST_HOLD: begin
          if (capture) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writeback register: load on capture, hold while stalled, clear once drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_tag     <= '0;
      wb_data    <= '0;
      wb_br_cond <= 1'b0;
    end else if (flush) begin
      wb_valid   <= 1'b0;
    end else if (capture) begin
      wb_valid   <= 1'b1;
      wb_data    <= alu_result;
      wb_br_cond <= alu_br_cond;
      wb_tag     <= issue ? req_tag[gidx] : TAG_W'(lat.tag);
    end else if (wb_valid && wb_ready) begin
      wb_valid   <= 1'b0;
      wb_tag     <= '0;
      wb_data    <= '0;
      wb_br_cond <= 1'b0;
    end
  end

  a_capture_result_valid: assert property (@(posedge clk) disable iff (!rst_n) capture |-> alu_result_valid);

`ifdef ALU_ISSUE_SCHED_PERF_EN
  // Saturating issue and stall counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && (perf_issue_cnt != '1)) perf_issue_cnt <= perf_issue_cnt + 1'b1;
      if ((|req_valid) && !can_issue && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - directed self-checking bench for alu_issue_sched
module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int MUL_LAT = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  instr_opcode        req_opcode [NUM_REQ];
  logic [31:0]        req_val1   [NUM_REQ];
  logic [31:0]        req_val2   [NUM_REQ];
  logic [TAG_W-1:0]   req_tag    [NUM_REQ];
  logic               alu_en;
  instr_opcode        alu_opcode;
  logic [31:0]        alu_val1;
  logic [31:0]        alu_val2;
  logic [31:0]        alu_result;
  logic               alu_result_valid;
  logic               alu_br_cond;
  logic               wb_valid;
  logic               wb_ready;
  logic [TAG_W-1:0]   wb_tag;
  logic [31:0]        wb_data;
  logic               wb_br_cond;
`ifdef ALU_ISSUE_SCHED_PERF_EN
  logic [31:0]        perf_issue_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_issue_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_opcode       (req_opcode),
    .req_val1         (req_val1),
    .req_val2         (req_val2),
    .req_tag          (req_tag),
    .alu_en           (alu_en),
    .alu_opcode       (alu_opcode),
    .alu_val1         (alu_val1),
    .alu_val2         (alu_val2),
    .alu_result       (alu_result),
    .alu_result_valid (alu_result_valid),
    .alu_br_cond      (alu_br_cond),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_tag           (wb_tag),
    .wb_data          (wb_data),
    .wb_br_cond       (wb_br_cond)
`ifdef ALU_ISSUE_SCHED_PERF_EN
    ,
    .perf_issue_cnt   (perf_issue_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  // Reference combinational ALU
  always_comb begin
    alu_result  = '0;
    alu_br_cond = 1'b0;
    case (alu_opcode)
      ADD_I:  alu_result  = alu_val1 + alu_val2;
      SUB_I:  alu_result  = alu_val1 - alu_val2;
      AND_I:  alu_result  = alu_val1 & alu_val2;
      OR_I:   alu_result  = alu_val1 | alu_val2;
      XOR_I:  alu_result  = alu_val1 ^ alu_val2;
      MUL_I:  alu_result  = alu_val1 * alu_val2;
      BEQ_I:  alu_br_cond = (alu_val1 == alu_val2);
      BNE_I:  alu_br_cond = (alu_val1 != alu_val2);
      BLT_I:  alu_br_cond = ($signed(alu_val1) < $signed(alu_val2));
      BGE_I:  alu_br_cond = ($signed(alu_val1) >= $signed(alu_val2));
      BLTU_I: alu_br_cond = (alu_val1 < alu_val2);
      BGEU_I: alu_br_cond = (alu_val1 >= alu_val2);
      default: ;
    endcase
  end
  assign alu_result_valid = alu_en;

  task automatic set_req(input int idx, input instr_opcode op, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [TAG_W-1:0] tag);
    req_opcode[idx] = op;
    req_val1[idx]   = v1;
    req_val2[idx]   = v2;
    req_tag[idx]    = tag;
  endtask

  task automatic test_reset;
    logic [3:0] exp_g;
    rst_n = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD_I, 32'(i * 10), 32'd1, TAG_W'(i + 8));
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); else n_pass++;
    n_checks++; if (alu_en !== 1'b0) $display("FAIL reset_alu_en: got %b expected 0", alu_en); else n_pass++;
    n_checks++; if (wb_data !== 32'd0) $display("FAIL reset_wb_data: got %h expected 0", wb_data); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_g = 4'b0001 << (k % 4);
      n_checks++; if (req_ready !== exp_g) $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_g); else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'(((k - 1) % 4) * 10 + 1) || wb_tag !== TAG_W'((k - 1) % 4 + 8))
          $display("FAIL rr_wb_%0d: got v=%b d=%0d t=%0d expected v=1 d=%0d t=%0d", k, wb_valid, wb_data, wb_tag,
                   ((k - 1) % 4) * 10 + 1, (k - 1) % 4 + 8);
        else n_pass++;
      end
    end
  endtask

  task automatic test_add_stall;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    set_req(2, ADD_I, 32'd5, 32'd7, 6'd9);
    req_valid = 4'b0100;
    wb_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL add_grant: got %b expected 0100", req_ready); else n_pass++;
    n_checks++; if (alu_en !== 1'b1 || alu_val1 !== 32'd5 || alu_val2 !== 32'd7) $display("FAIL add_alu_drive: got en=%b v1=%0d v2=%0d expected en=1 v1=5 v2=7", alu_en, alu_val1, alu_val2); else n_pass++;
    @(negedge clk);
    set_req(0, ADD_I, 32'd1, 32'd1, 6'd1);
    set_req(1, ADD_I, 32'd2, 32'd2, 6'd2);
    set_req(3, ADD_I, 32'd4, 32'd4, 6'd3);
    req_valid = 4'b1011;
    #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd12 || wb_tag !== 6'd9) $display("FAIL add_wb: got v=%b d=%0d t=%0d expected v=1 d=12 t=9", wb_valid, wb_data, wb_tag); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL stall_no_grant_1: got %b expected 0000", req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000 || wb_data !== 32'd12) $display("FAIL stall_hold: got rdy=%b d=%0d expected rdy=0000 d=12", req_ready, wb_data); else n_pass++;
    wb_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL stall_release_grant: got %b expected 1000", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd8 || wb_tag !== 6'd3) $display("FAIL back_to_back_wb: got v=%b d=%0d t=%0d expected v=1 d=8 t=3", wb_valid, wb_data, wb_tag); else n_pass++;
  endtask

  task automatic test_mul;
    @(negedge clk);
    set_req(1, MUL_I, 32'hFFFF_FFFE, 32'd3, 6'd5);
    req_valid = 4'b0010;
    wb_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL mul_grant: got %b expected 0010", req_ready); else n_pass++;
    for (int c = 1; c < MUL_LAT; c++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || wb_valid !== 1'b0 || alu_en !== 1'b1 || alu_opcode !== MUL_I || alu_val1 !== 32'hFFFF_FFFE)
        $display("FAIL mul_busy_%0d: got rdy=%b v=%b en=%b op=%0d v1=%h expected rdy=0000 v=0 en=1 op=%0d v1=fffffffe",
                 c, req_ready, wb_valid, alu_en, alu_opcode, alu_val1, MUL_I);
      else n_pass++;
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FFFA || wb_tag !== 6'd5) $display("FAIL mul_result: got v=%b d=%h t=%0d expected v=1 d=fffffffa t=5", wb_valid, wb_data, wb_tag); else n_pass++;
  endtask

  task automatic test_branch;
    @(negedge clk);
    set_req(2, BLT_I, 32'hFFFF_FFFF, 32'd1, 6'd12);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL blt_grant: got %b expected 0100", req_ready); else n_pass++;
    @(negedge clk);
    set_req(3, BLTU_I, 32'hFFFF_FFFF, 32'd1, 6'd13);
    req_valid = 4'b1000;
    #1;
    n_checks++; if (wb_br_cond !== 1'b1 || wb_tag !== 6'd12) $display("FAIL blt_cond: got c=%b t=%0d expected c=1 t=12", wb_br_cond, wb_tag); else n_pass++;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL bltu_grant: got %b expected 1000", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_br_cond !== 1'b0 || wb_tag !== 6'd13) $display("FAIL bltu_cond: got v=%b c=%b t=%0d expected v=1 c=0 t=13", wb_valid, wb_br_cond, wb_tag); else n_pass++;
  endtask

  task automatic test_flush;
    @(negedge clk);
    set_req(1, MUL_I, 32'd6, 32'd7, 6'd3);
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL flush_mul_grant: got %b expected 0010", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    flush = 1'b1;
    set_req(2, ADD_I, 32'd100, 32'd23, 6'd4);
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL flush_req_ready: got %b expected 0000", req_ready); else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL flush_drop: got wb_valid=%b expected 0", wb_valid); else n_pass++;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL flush_next_grant: got %b expected 0100", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd123 || wb_tag !== 6'd4) $display("FAIL flush_after_wb: got v=%b d=%0d t=%0d expected v=1 d=123 t=4", wb_valid, wb_data, wb_tag); else n_pass++;
  endtask

  task automatic test_reset_mid_mul;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    set_req(0, MUL_I, 32'd9, 32'd9, 6'd7);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmul_grant: got %b expected 0001", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_checks++; if (alu_en !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rmul_in_reset: got en=%b v=%b expected en=0 v=0", alu_en, wb_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < MUL_LAT; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if (wb_valid !== 1'b0) $display("FAIL rmul_no_emit_%0d: got wb_valid=%b expected 0", c, wb_valid); else n_pass++;
    end
    set_req(0, ADD_I, 32'd1, 32'd2, 6'd1);
    req_valid = 4'b0101;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmul_ptr_reset: got %b expected 0001", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

`ifdef ALU_ISSUE_SCHED_PERF_EN
  task automatic test_perf;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b0000;
    wb_ready = 1'b0;
    #1;
    n_checks++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) $display("FAIL perf_reset: got i=%0d s=%0d expected 0 0", perf_issue_cnt, perf_stall_cnt); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD_I, 32'(i), 32'd1, TAG_W'(i));
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    @(negedge clk);
    wb_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_checks++; if (perf_issue_cnt !== 32'd4) $display("FAIL perf_issue: got %0d expected 4", perf_issue_cnt); else n_pass++;
    n_checks++; if (perf_stall_cnt !== 32'd3) $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt); else n_pass++;
  endtask
`endif

  initial begin
    req_valid = 4'b0000;
    wb_ready  = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD_I, 32'd0, 32'd0, '0);
    test_reset();
    test_add_stall();
    test_mul();
    test_branch();
    test_flush();
    test_reset_mid_mul();
`ifdef ALU_ISSUE_SCHED_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
